cipher_stream_feeder: RTL and testbench
=======================================

Name: cipher_stream_feeder

Overview:
- Upstream feeder for the hex encrypt/decrypt core.
- Accepts a valid/ready stream of 4-bit symbols, each with a public key, and buffers them in a small FIFO.
- Drives each symbol to the core as a one-hot 16-bit hexadecimal word, waits for the core to settle, then captures the core's encrypted data, private key and decoded hex output.
- Emits one result per symbol on a valid/ready output stream, with a round-trip match flag and a saturating mismatch counter.

Parameters:
- FIFO_DEPTH, 4, input FIFO entries; power of 2, minimum 2.
- SETTLE_CYCLES, 2, cycles the one-hot word and key are held before capture; minimum 1.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input symbol valid
- in_ready  out  1  FIFO can accept a symbol
- in_symbol  in  4  binary symbol 0..15
- in_key  in  4  public key for this symbol
- core_hex_in  out  16  one-hot word to the core's hexadecimal_input
- core_pub_key  out  4  to the core's public_key
- core_encrypt  in  4  core encrypt_data
- core_prv_key  in  4  core private_key
- core_hex_out  in  16  core hexadecimal_output
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_symbol  out  4  symbol that produced the result
- out_encrypt  out  4  captured encrypt_data
- out_prv_key  out  4  captured private_key
- out_match  out  1  core_hex_out equalled core_hex_in at capture
- err_count  out  ERR_W  saturating count of mismatches
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous assert, synchronous release): FIFO empty, state IDLE. All of the following are 0: in_ready, core_hex_in, core_pub_key, out_valid, out_symbol, out_encrypt, out_prv_key, out_match, err_count, fifo_level.
- in_ready goes high the first cycle after reset deasserts.
- FIFO push: occurs when in_valid && in_ready. in_ready = (fifo_level < FIFO_DEPTH).
- Full-FIFO push: with in_ready low, in_valid is ignored; no data is lost or overwritten.
- Simultaneous push and pop: allowed in the same cycle; level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, DRIVE, CAPTURE, PRESENT.
- IDLE:
  - core_hex_in = 0 and core_pub_key = 0.
  - If the FIFO is non-empty: pop the head, register core_hex_in = 1 << symbol and core_pub_key = key, load settle counter = SETTLE_CYCLES-1, go to DRIVE.
- DRIVE:
  - Hold core outputs stable.
  - Decrement the counter; at 0, go to CAPTURE.
- CAPTURE (one cycle):
  - Register out_encrypt, out_prv_key and out_symbol.
  - Set out_match = (core_hex_out == core_hex_in).
  - If there is a mismatch and err_count is below all-ones, increment err_count; it saturates and never wraps.
  - Set out_valid = 1 and go to PRESENT.
- PRESENT:
  - Hold all out_* stable while out_valid && !out_ready.
  - On out_ready: clear out_valid, drive core outputs to 0, return to IDLE.
- Latency:
  - Pop to out_valid is SETTLE_CYCLES+1 cycles.
  - Minimum throughput is one symbol per SETTLE_CYCLES+3 cycles with out_ready held high.
- Downstream backpressure stalls the FSM only; the FIFO keeps accepting symbols until full.
- Mid-operation reset: the in-flight symbol and all FIFO contents are discarded and no partial result is emitted.
- Encoding rule: core_hex_in is exactly one-hot whenever the state is not IDLE.

Decomposition:
- Shared package cipher_pkg:
  - State enum (IDLE, DRIVE, CAPTURE, PRESENT).
  - SYM_W=4, HEX_W=16, KEY_W=4 constants.
  - onehot16 function.
- One sub-module, sync_fifo:
  - Parameterised width and depth.
  - push/pop, full/empty, level.
  - Instantiated with width 8 ({key, symbol}).

Test Plan:
- Single symbol, SETTLE_CYCLES=2: symbol 0x5, key 0xF, out_ready=1 -> core_hex_in=0x0020 for 3 cycles; out_valid 3 cycles after pop; out_symbol=5; out_encrypt/out_prv_key equal the core values sampled at CAPTURE.
- FIFO fill: push 5 symbols back-to-back with out_ready=0 -> 4 of them in the FIFO while the FSM holds a 5th in PRESENT; in_ready low once full; fifo_level=4; nothing dropped. Releasing out_ready drains all 5 in order.
- Round-trip checking: model the core with hex_out = hex_in -> out_match=1 and err_count stays 0. Model it with hex_out=0 -> out_match=0 and err_count increments once per result.
- Counter saturation: with ERR_W=2, send 5 mismatching symbols -> err_count = 3 after the 3rd and stays 3.
- Simultaneous push and pop: at level 2, push on the same cycle the FSM pops -> level remains 2; output order preserved.
- Reset mid-DRIVE with the FIFO holding 3 entries -> all outputs 0 immediately; fifo_level=0; no out_valid after release; in_ready=1 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared types and helpers for the cipher stream feeder and its FIFO.
package cipher_pkg;

    localparam int SYM_W = 4;
    localparam int HEX_W = 16;
    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

    function automatic logic [HEX_W-1:0] onehot16(input logic [SYM_W-1:0] sym);
        return HEX_W'(1) << sym;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; depth must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push && !do_pop)      lvl_d = lvl_q + 1'b1;
        else if (!do_push && do_pop) lvl_d = lvl_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (lvl_q == LVL_W'(DEPTH));
    assign empty_o = (lvl_q == '0);
    assign level_o = lvl_q;

endmodule

// File: rtl/cipher_stream_feeder.sv
// Buffers symbols, drives them one-hot into the hex cipher core, and returns
// the captured core results with a round-trip match flag and error count.
module cipher_stream_feeder
    import cipher_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SYM_W-1:0]              in_symbol,
    input  logic [KEY_W-1:0]              in_key,
    output logic [HEX_W-1:0]              core_hex_in,
    output logic [KEY_W-1:0]              core_pub_key,
    input  logic [KEY_W-1:0]              core_encrypt,
    input  logic [KEY_W-1:0]              core_prv_key,
    input  logic [HEX_W-1:0]              core_hex_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SYM_W-1:0]              out_symbol,
    output logic [KEY_W-1:0]              out_encrypt,
    output logic [KEY_W-1:0]              out_prv_key,
    output logic                          out_match,
    output logic [ERR_W-1:0]              err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [HEX_W-1:0]     hex_q, hex_d;
    logic [KEY_W-1:0]     pub_q, pub_d;
    logic [SYM_W-1:0]     sym_q, sym_d;
    logic                 ovld_q, ovld_d;
    logic [SYM_W-1:0]     osym_q, osym_d;
    logic [KEY_W-1:0]     oenc_q, oenc_d;
    logic [KEY_W-1:0]     oprv_q, oprv_d;
    logic                 omatch_q, omatch_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 rdy_en_q;

    logic                     fifo_full, fifo_empty, pop;
    logic [KEY_W+SYM_W-1:0]   head;

    // rdy_en_q keeps in_ready low until the first clock after reset releases.
    assign in_ready = rdy_en_q && !fifo_full;
    assign pop      = (state_q == ST_IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (KEY_W + SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid && in_ready),
        .data_i  ({in_key, in_symbol}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hex_d    = hex_q;
        pub_d    = pub_q;
        sym_d    = sym_q;
        ovld_d   = ovld_q;
        osym_d   = osym_q;
        oenc_d   = oenc_q;
        oprv_d   = oprv_q;
        omatch_d = omatch_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                hex_d = '0;
                pub_d = '0;
                if (!fifo_empty) begin
                    sym_d   = head[SYM_W-1:0];
                    hex_d   = onehot16(head[SYM_W-1:0]);
                    pub_d   = head[KEY_W+SYM_W-1:SYM_W];
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) state_d = ST_CAPTURE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_CAPTURE: begin
                osym_d   = sym_q;
                oenc_d   = core_encrypt;
                oprv_d   = core_prv_key;
                omatch_d = (core_hex_out == hex_q);
                if ((core_hex_out != hex_q) && (err_q != {ERR_W{1'b1}}))
                    err_d = err_q + 1'b1;
                ovld_d   = 1'b1;
                state_d  = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    ovld_d  = 1'b0;
                    hex_d   = '0;
                    pub_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hex_q    <= '0;
            pub_q    <= '0;
            sym_q    <= '0;
            ovld_q   <= 1'b0;
            osym_q   <= '0;
            oenc_q   <= '0;
            oprv_q   <= '0;
            omatch_q <= 1'b0;
            err_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hex_q    <= hex_d;
            pub_q    <= pub_d;
            sym_q    <= sym_d;
            ovld_q   <= ovld_d;
            osym_q   <= osym_d;
            oenc_q   <= oenc_d;
            oprv_q   <= oprv_d;
            omatch_q <= omatch_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign core_hex_in  = hex_q;
    assign core_pub_key = pub_q;
    assign out_valid    = ovld_q;
    assign out_symbol   = osym_q;
    assign out_encrypt  = oenc_q;
    assign out_prv_key  = oprv_q;
    assign out_match    = omatch_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_cipher_stream_feeder.sv
// Randomised and directed bench for cipher_stream_feeder with a behavioural
// core model and a queue-based reference of the expected result stream.
module tb_cipher_stream_feeder;
    localparam int FD = 4;
    localparam int SC = 2;
    localparam int EW = 2;
    localparam int EMAX = (1 << EW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [3:0]  in_symbol, in_key;
    logic [15:0] core_hex_in, core_hex_out;
    logic [3:0]  core_pub_key, core_encrypt, core_prv_key;
    logic        out_valid, out_ready;
    logic [3:0]  out_symbol, out_encrypt, out_prv_key;
    logic        out_match;
    logic [EW-1:0] err_count;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    cipher_stream_feeder #(
        .FIFO_DEPTH(FD), .SETTLE_CYCLES(SC), .ERR_W(EW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_symbol(in_symbol), .in_key(in_key),
        .core_hex_in(core_hex_in), .core_pub_key(core_pub_key),
        .core_encrypt(core_encrypt), .core_prv_key(core_prv_key),
        .core_hex_out(core_hex_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_symbol(out_symbol), .out_encrypt(out_encrypt),
        .out_prv_key(out_prv_key), .out_match(out_match),
        .err_count(err_count), .fifo_level(fifo_level)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural core: 0 = echoes the hex word, 1 = returns zero,
    // 2 = returns zero for odd symbols only.
    logic [1:0] core_mode;
    logic [3:0] cidx;

    function automatic logic [3:0] prv_of(input logic [3:0] k);
        return {k[0], k[3:1]} ^ 4'hA;
    endfunction

    function automatic logic match_of(input logic [1:0] mode, input logic [3:0] s);
        case (mode)
            2'd0:    return 1'b1;
            2'd1:    return 1'b0;
            default: return !s[0];
        endcase
    endfunction

    always_comb begin
        cidx = 4'd0;
        for (int i = 0; i < 16; i++) if (core_hex_in[i]) cidx = 4'(i);
    end
    assign core_encrypt = cidx + core_pub_key;
    assign core_prv_key = prv_of(core_pub_key);
    assign core_hex_out = match_of(core_mode, cidx) ? core_hex_in : 16'h0000;

    typedef struct { logic [3:0] sym; logic [3:0] key; } item_t;
    item_t q_m[$];
    int    err_m = 0;
    int    n_res = 0;
    logic  stall_prev = 1'b0;
    logic [12:0] snap;

    always @(negedge clk) begin
        item_t e;
        logic  m;
        if (reset) begin
            q_m.delete();
            err_m = 0;
            stall_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q_m.size() == 0) begin
                    chk("unexpected_result", 32'(1), 32'(0));
                end else begin
                    e = q_m.pop_front();
                    m = match_of(core_mode, e.sym);
                    if (!m && err_m < EMAX) err_m++;
                    chk("res_symbol", 32'(out_symbol), 32'(e.sym));
                    chk("res_encrypt", 32'(out_encrypt), 32'(4'(e.sym + e.key)));
                    chk("res_prv_key", 32'(out_prv_key), 32'(prv_of(e.key)));
                    chk("res_match", 32'(out_match), 32'(m));
                    chk("res_err_count", 32'(err_count), 32'(err_m));
                    n_res++;
                end
            end
            if (in_valid && in_ready) q_m.push_back('{sym: in_symbol, key: in_key});
            if (out_valid && !out_ready) begin
                if (stall_prev)
                    chk("stall_hold", 32'({out_symbol, out_encrypt, out_prv_key, out_match}), 32'(snap));
                snap = {out_symbol, out_encrypt, out_prv_key, out_match};
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] s, input logic [3:0] k);
        bit done = 0;
        in_valid = 1'b1;
        in_symbol = s;
        in_key = k;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) done = 1;
            step();
        end
        if (!done) chk("push_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 300 && (q_m.size() != 0 || out_valid); i++) step();
        chk(tag, 32'(q_m.size()), 32'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    task automatic fill5(input logic [3:0] base);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_one(4'(base + 4'(i)), 4'(i * 3));
    endtask

    initial begin
        int base, seen;
        reset = 1'b1; in_valid = 1'b0; in_symbol = '0; in_key = '0;
        out_ready = 1'b0; core_mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_core_hex_in", 32'(core_hex_in), 32'(0));
        chk("rst_core_pub_key", 32'(core_pub_key), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_fields", 32'({out_symbol, out_encrypt, out_prv_key, out_match}), 32'(0));
        chk("rst_err_count", 32'(err_count), 32'(0));
        chk("rst_fifo_level", 32'(fifo_level), 32'(0));
        reset = 1'b0;
        chk("ready_before_edge", 32'(in_ready), 32'(0));
        step();
        chk("ready_after_release", 32'(in_ready), 32'(1));

        // Single symbol latency and hold
        out_ready = 1'b1;
        chk("t1_idle_hex", 32'(core_hex_in), 32'(0));
        in_valid = 1'b1; in_symbol = 4'h5; in_key = 4'hF;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1_hex_hold", 32'(core_hex_in), 32'h0020);
            chk("t1_key_hold", 32'(core_pub_key), 32'hF);
            chk("t1_vld_low", 32'(out_valid), 32'(0));
        end
        step();
        chk("t1_vld_high", 32'(out_valid), 32'(1));
        chk("t1_symbol", 32'(out_symbol), 32'(5));
        step();
        chk("t1_vld_clear", 32'(out_valid), 32'(0));
        chk("t1_hex_clear", 32'(core_hex_in), 32'(0));
        chk("t1_err_zero", 32'(err_count), 32'(0));

        // FIFO fill under backpressure, then ordered drain
        fill5(4'h8);
        in_valid = 1'b1; in_symbol = 4'hE; in_key = 4'h1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fill_in_ready", 32'(in_ready), 32'(0));
            chk("fill_level", 32'(fifo_level), 32'(4));
            chk("fill_presenting", 32'(out_valid), 32'(1));
        end
        in_valid = 1'b0;
        base = n_res;
        drain("fill_drain");
        chk("fill_count", 32'(n_res - base), 32'(5));

        // Simultaneous push and pop at level 2
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(4'(i + 1), 4'(7 - i));
        for (int i = 0; i < 50 && !out_valid; i++) step();
        chk("sim_vld", 32'(out_valid), 32'(1));
        chk("sim_level_pre", 32'(fifo_level), 32'(2));
        out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_symbol = 4'hC; in_key = 4'h3;
        chk("sim_level_mid", 32'(fifo_level), 32'(2));
        step();
        in_valid = 1'b0;
        chk("sim_level_post", 32'(fifo_level), 32'(2));
        drain("sim_drain");

        // All mismatches: counter saturates
        core_mode = 2'd1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_one(4'(i * 2), 4'(i));
        drain("sat_drain");
        chk("sat_err_count", 32'(err_count), 32'(EMAX));

        // Randomised bursts across core behaviours
        for (int b = 0; b < 6; b++) begin
            core_mode = 2'(b % 3);
            do_reset();
            for (int c = 0; c < 80; c++) begin
                in_valid  = ($urandom_range(0, 1) == 1);
                in_symbol = 4'($urandom());
                in_key    = 4'($urandom());
                out_ready = ($urandom_range(0, 9) < 6);
                step();
            end
            in_valid = 1'b0;
            drain("rand_drain");
        end

        // Reset while a symbol is in DRIVE with three entries queued
        core_mode = 2'd0;
        do_reset();
        fill5(4'h2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        chk("mid_level", 32'(fifo_level), 32'(3));
        chk("mid_driving", 32'(core_hex_in), 32'h0008);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_hex", 32'(core_hex_in), 32'(0));
        chk("mid_rst_key", 32'(core_pub_key), 32'(0));
        chk("mid_rst_vld", 32'(out_valid), 32'(0));
        chk("mid_rst_level", 32'(fifo_level), 32'(0));
        chk("mid_rst_ready", 32'(in_ready), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("mid_ready_low", 32'(in_ready), 32'(0));
        step();
        chk("mid_ready_high", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (out_valid) seen++;
        end
        chk("mid_no_result", 32'(seen), 32'(0));
        chk("mid_level_after", 32'(fifo_level), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog sim_time=%0t limit=300000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
